solver_iter_ctrl: RTL and testbench

- Parametrised successor to the single-mode escape-time solver controller.
- Sequences one multi-limb fixed-point solver datapath through load, optional abs pass, limb-serial squaring/accumulate iteration, flush and divergence check.
- Adds: selectable fractal mode (Mandelbrot / Burning Ship), configurable iteration width and flush depth, valid/ready job and result handshakes, and synchronous abort.
- Sits between the pixel job dispatcher and the solver datapath.

---
 rtl/solver_iter_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_solver_iter_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/solver_iter_ctrl.sv
// Sequencer for one multi-limb fixed-point escape-time solver datapath.
// Walks load, optional abs pass, limb-serial squaring, flush and divergence check per pixel job.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for a job; job_ready high
// S_ABS        | Burning Ship abs pass, limb N-1 down to 0, one per cycle
// S_ABS_FLUSH  | drain datapath after abs pass (FLUSH_WAIT+1 cycles)
// S_ITER       | partial-product steps, k=N..0, p=0..k>>1, two cycles per p
// S_ITER_FLUSH | drain datapath after squaring (FLUSH_WAIT+1 cycles)
// S_CHECK      | sample diverged, decide escape / limit / next iteration
// S_DONE       | result presented until res_ready
module solver_iter_ctrl #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int ITER_BITS       = 16,
   parameter int FLUSH_WAIT      = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
   input  logic [ITER_BITS-1:0]       cfg_iter_lim,
   input  logic                       cfg_mode,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic                       abort,
   output logic                       step_valid,
   output logic [LIMB_INDEX_BITS-1:0] zre_rd_ind,
   output logic [LIMB_INDEX_BITS-1:0] zim_rd_ind,
   output logic                       step_flip,
   output logic                       step_first,
   output logic                       abs_en,
   output logic                       z_wr_en,
   output logic [LIMB_INDEX_BITS-1:0] z_wr_ind,
   input  logic                       diverged,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [ITER_BITS-1:0]       res_count,
   output logic                       res_escaped
);

   localparam int FW_BITS = (FLUSH_WAIT < 1) ? 1 : $clog2(FLUSH_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS,
      S_ABS_FLUSH,
      S_ITER,
      S_ITER_FLUSH,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [LIMB_INDEX_BITS-1:0] n_q;
   logic [LIMB_INDEX_BITS-1:0] k_q;
   logic [LIMB_INDEX_BITS-1:0] p_q;
   logic [LIMB_INDEX_BITS-1:0] abs_ind_q;
   logic                       flip_q;
   logic [FW_BITS-1:0]         flush_q;
   logic [ITER_BITS-1:0]       lim_q;
   logic [ITER_BITS-1:0]       count_q;
   logic                       mode_q;
   logic                       escaped_q;

   logic [LIMB_INDEX_BITS-1:0] half_k;
   logic [LIMB_INDEX_BITS-1:0] k_minus_p;
   logic                       pair_end;
   logic                       iter_last;
   logic                       iter_commit;
   logic                       flush_done;
   logic                       chk_escape;
   logic                       chk_limit;
   logic                       job_accept;

   assign half_k      = k_q >> 1;
   assign k_minus_p   = k_q - p_q;
   assign pair_end    = flip_q && (p_q == half_k);
   assign iter_last   = pair_end && (k_q == '0);
   // Limb N is only a carry-in contribution; limbs below N are committed.
   assign iter_commit = (state_q == S_ITER) && pair_end && (k_q < n_q);
   assign flush_done  = (flush_q == '0);
   // At count 0 z is still zero, so a divergence indication there is meaningless.
   assign chk_escape  = diverged && (count_q != '0);
   assign chk_limit   = (count_q == (lim_q - ITER_BITS'(1)));
   assign job_accept  = (state_q == S_IDLE) && job_valid && !abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      job_ready   = 1'b0;
      step_valid  = 1'b0;
      zre_rd_ind  = '0;
      zim_rd_ind  = '0;
      step_flip   = 1'b0;
      step_first  = 1'b0;
      abs_en      = 1'b0;
      z_wr_en     = 1'b0;
      z_wr_ind    = '0;
      res_valid   = 1'b0;

      case (state_q)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_d = S_ITER;
         end
         S_ABS: begin
            abs_en     = 1'b1;
            z_wr_en    = 1'b1;
            z_wr_ind   = abs_ind_q;
            zre_rd_ind = abs_ind_q;
            if (abs_ind_q == '0) state_d = S_ABS_FLUSH;
         end
         S_ABS_FLUSH: begin
            if (flush_done) state_d = S_ITER;
         end
         S_ITER: begin
            step_valid = 1'b1;
            step_flip  = flip_q;
            step_first = (p_q == '0) && !flip_q;
            zre_rd_ind = flip_q ? p_q : k_minus_p;
            zim_rd_ind = flip_q ? k_minus_p : p_q;
            if (iter_commit) begin
               z_wr_en  = 1'b1;
               z_wr_ind = k_q;
            end
            if (iter_last) state_d = S_ITER_FLUSH;
         end
         S_ITER_FLUSH: begin
            if (flush_done) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (chk_escape || chk_limit) state_d = S_DONE;
            else if (mode_q)             state_d = S_ABS;
            else                         state_d = S_ITER;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort outranks every other event, including a new job in IDLE.
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         n_q       <= '0;
         k_q       <= '0;
         p_q       <= '0;
         abs_ind_q <= '0;
         flip_q    <= 1'b0;
         flush_q   <= '0;
         lim_q     <= '0;
         count_q   <= '0;
         mode_q    <= 1'b0;
         escaped_q <= 1'b0;
      end else begin
         if (job_accept) begin
            n_q       <= cfg_num_limbs;
            lim_q     <= cfg_iter_lim;
            mode_q    <= cfg_mode;
            count_q   <= '0;
            escaped_q <= 1'b0;
         end

         if (state_d == S_ITER && state_q != S_ITER) begin
            k_q    <= (state_q == S_IDLE) ? cfg_num_limbs : n_q;
            p_q    <= '0;
            flip_q <= 1'b0;
         end else if (state_q == S_ITER) begin
            if (flip_q) begin
               flip_q <= 1'b0;
               if (pair_end) begin
                  p_q <= '0;
                  k_q <= k_q - LIMB_INDEX_BITS'(1);
               end else begin
                  p_q <= p_q + LIMB_INDEX_BITS'(1);
               end
            end else begin
               flip_q <= 1'b1;
            end
         end

         if ((state_d == S_ITER_FLUSH && state_q != S_ITER_FLUSH) ||
             (state_d == S_ABS_FLUSH  && state_q != S_ABS_FLUSH)) begin
            flush_q <= FW_BITS'(FLUSH_WAIT);
         end else if ((state_q == S_ITER_FLUSH || state_q == S_ABS_FLUSH) && !flush_done) begin
            flush_q <= flush_q - FW_BITS'(1);
         end

         if (state_d == S_ABS && state_q != S_ABS) begin
            abs_ind_q <= n_q - LIMB_INDEX_BITS'(1);
         end else if (state_q == S_ABS && abs_ind_q != '0) begin
            abs_ind_q <= abs_ind_q - LIMB_INDEX_BITS'(1);
         end

         if (state_q == S_CHECK) begin
            if (state_d == S_DONE) begin
               escaped_q <= chk_escape;
            end else if (state_d == S_ITER || state_d == S_ABS) begin
               count_q <= count_q + ITER_BITS'(1);
            end
         end
      end
   end

   assign res_count   = count_q;
   assign res_escaped = escaped_q;

endmodule

// File: tb/tb_solver_iter_ctrl.sv
// Bench for solver_iter_ctrl: directed scenarios plus random jobs, each checked
// cycle by cycle against an expected-output schedule built from the iteration rules.
module tb_solver_iter_ctrl;

   localparam int LB = 6;
   localparam int IB = 16;
   localparam int FW = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [LB-1:0] cfg_num_limbs = '0;
   logic [IB-1:0] cfg_iter_lim = '0;
   logic          cfg_mode = 1'b0;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic          abort = 1'b0;
   logic          step_valid;
   logic [LB-1:0] zre_rd_ind;
   logic [LB-1:0] zim_rd_ind;
   logic          step_flip;
   logic          step_first;
   logic          abs_en;
   logic          z_wr_en;
   logic [LB-1:0] z_wr_ind;
   logic          diverged = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [IB-1:0] res_count;
   logic          res_escaped;

   int n_cmp = 0;
   int n_mis = 0;

   logic [31:0] exp_q[$];
   bit          chk_q[$];

   solver_iter_ctrl #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .FLUSH_WAIT(FW)) dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim), .cfg_mode(cfg_mode),
      .job_valid(job_valid), .job_ready(job_ready), .abort(abort),
      .step_valid(step_valid), .zre_rd_ind(zre_rd_ind), .zim_rd_ind(zim_rd_ind),
      .step_flip(step_flip), .step_first(step_first), .abs_en(abs_en),
      .z_wr_en(z_wr_en), .z_wr_ind(z_wr_ind), .diverged(diverged),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_count(res_count), .res_escaped(res_escaped)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Layout: sv[24] zre[23:18] zim[17:12] flip[11] first[10] abs[9] we[8] wi[7:2] jr[1] rv[0]
   function automatic logic [31:0] pack(bit sv, int zre, int zim, bit fl, bit fi,
                                        bit ab, bit we, int wi, bit jr, bit rv);
      return {7'b0, sv, LB'(zre), LB'(zim), fl, fi, ab, we, LB'(wi), jr, rv};
   endfunction

   // Index outputs are only meaningful while their strobe is expected.
   function automatic logic [31:0] observe(logic [31:0] e);
      logic [LB-1:0] zre, zim, wi;
      zre = (e[24] || e[9]) ? zre_rd_ind : '0;
      zim = e[24] ? zim_rd_ind : '0;
      wi  = e[8] ? z_wr_ind : '0;
      return {7'b0, step_valid, zre, zim, step_flip, step_first, abs_en, z_wr_en, wi,
              job_ready, res_valid};
   endfunction

   task automatic push(logic [31:0] v, bit c);
      exp_q.push_back(v);
      chk_q.push_back(c);
   endtask

   // Expected cycle schedule of one job from acceptance to the cycle before DONE.
   task automatic build(int n, int l, bit mode, int div_at, output int cnt, output bit esc);
      exp_q.delete();
      chk_q.delete();
      cnt = 0;
      esc = 1'b0;
      for (int i = 0; i < l; i++) begin
         if (i > 0 && mode) begin
            for (int a = n - 1; a >= 0; a--) push(pack(0, a, 0, 0, 0, 1, 1, a, 0, 0), 0);
            for (int f = 0; f <= FW; f++) push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
         end
         for (int k = n; k >= 0; k--) begin
            for (int p = 0; p <= k / 2; p++) begin
               for (int f = 0; f < 2; f++) begin
                  bit last;
                  last = (f == 1) && (p == k / 2) && (k < n);
                  push(pack(1, (f == 1) ? p : k - p, (f == 1) ? k - p : p, f == 1,
                            (p == 0) && (f == 0), 0, last, last ? k : 0, 0, 0), 0);
               end
            end
         end
         for (int f = 0; f <= FW; f++) push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
         push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
         cnt = i;
         if (i > 0 && div_at == i) begin
            esc = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_job(string name, int n, int l, bit mode, int div_at, int hold,
                          int abort_at, bit abort_done, int reset_at);
      int          exp_cnt;
      bit          exp_esc;
      int          ci;
      logic [31:0] idle_v;
      logic [31:0] done_v;
      idle_v = pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      done_v = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      build(n, l, mode, div_at, exp_cnt, exp_esc);
      @(negedge clock);
      check($sformatf("%s:idle_before", name), observe(idle_v), idle_v);
      cfg_num_limbs = LB'(n);
      cfg_iter_lim  = IB'(l);
      cfg_mode      = mode;
      job_valid     = 1'b1;
      ci = 0;
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge clock);
         job_valid     = 1'b0;
         cfg_num_limbs = LB'($urandom);
         cfg_iter_lim  = IB'($urandom);
         cfg_mode      = 1'($urandom);
         check($sformatf("%s:cyc%0d", name, c), observe(exp_q[c]), exp_q[c]);
         if (chk_q[c]) begin
            diverged = (ci == div_at);
            ci++;
         end else begin
            diverged = 1'($urandom);
         end
         if (c == abort_at) begin
            abort = 1'b1;
            @(negedge clock);
            abort    = 1'b0;
            diverged = 1'b0;
            for (int r = 0; r < 3; r++) begin
               check($sformatf("%s:after_abort%0d", name, r), observe(idle_v), idle_v);
               @(negedge clock);
            end
            return;
         end
         if (c == reset_at) begin
            #2 reset_n = 1'b0;
            #1;
            check($sformatf("%s:reset_outputs", name), observe(idle_v), idle_v);
            check($sformatf("%s:reset_result", name), {15'b0, res_escaped, res_count}, 32'h0);
            @(negedge clock);
            reset_n  = 1'b1;
            diverged = 1'b0;
            #1;
            check($sformatf("%s:ready_after_reset", name), observe(idle_v), idle_v);
            return;
         end
      end
      @(negedge clock);
      diverged = 1'b0;
      check($sformatf("%s:done", name), observe(done_v), done_v);
      check($sformatf("%s:result", name), {15'b0, res_escaped, res_count},
            {15'b0, exp_esc, IB'(exp_cnt)});
      if (abort_done) begin
         abort     = 1'b1;
         res_ready = 1'b1;
         @(negedge clock);
         abort     = 1'b0;
         res_ready = 1'b0;
         for (int r = 0; r < 3; r++) begin
            check($sformatf("%s:done_abort%0d", name, r), observe(idle_v), idle_v);
            @(negedge clock);
         end
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         diverged = 1'($urandom);
         check($sformatf("%s:hold%0d", name, h), observe(done_v), done_v);
         check($sformatf("%s:hold_res%0d", name, h), {15'b0, res_escaped, res_count},
               {15'b0, exp_esc, IB'(exp_cnt)});
      end
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
      diverged  = 1'b0;
      check($sformatf("%s:released", name), observe(idle_v), idle_v);
   endtask

   initial begin
      #12;
      check("reset_outputs", observe(pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)),
            pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      check("reset_result", {15'b0, res_escaped, res_count}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      run_job("mb_n2_l3",    2, 3, 0, 99, 0,  -1, 0, -1);
      run_job("bs_n3_l5",    3, 5, 1, 1,  0,  -1, 0, -1);
      run_job("div_first",   2, 1, 0, 0,  0,  -1, 0, -1);
      run_job("backpress",   1, 2, 1, 99, 10, -1, 0, -1);
      run_job("abort_iter",  3, 4, 0, 99, 0,  5,  0, -1);
      run_job("after_abort", 1, 2, 0, 99, 0,  -1, 0, -1);
      run_job("abort_done",  2, 2, 1, 99, 0,  -1, 1, -1);
      run_job("after_abort2",1, 2, 0, 99, 0,  -1, 0, -1);
      run_job("reset_abs",   3, 3, 1, 99, 0,  -1, 0, 19);
      run_job("after_reset", 2, 2, 1, 1,  0,  -1, 0, -1);

      for (int j = 0; j < 10; j++) begin
         int n, l, d;
         n = int'($urandom_range(1, 5));
         l = int'($urandom_range(1, 4));
         d = int'($urandom_range(0, 4));
         run_job($sformatf("rnd%0d", j), n, l, 1'($urandom), d,
                 int'($urandom_range(0, 3)), -1, 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
